// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the iterative multiply/divide sequencer.
// Op encoding follows the MIPS HI/LO instruction group.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX
  } muldiv_state_t;

  function automatic logic is_signed(muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div(muldiv_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the
// multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int N = 32
);
  import muldiv_pkg::*;

  logic         start;
  muldiv_op_t   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cancel;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic         div_zero;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo, div_zero
  );

endinterface

// File: rtl/muldiv_sequencer_alu.sv
// Shared N-bit adder/subtractor; co is carry on add and
// borrow on subtract.
module alu_arithmatic #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] s,
  output logic         co
);

  logic [N:0] sum;

  assign sum = {1'b0, x}
             + {1'b0, y ^ {N{sub}}}
             + {{N{1'b0}}, sub};
  assign s   = sum[N-1:0];
  assign co  = sum[N] ^ sub;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU: N shift-add or restoring
// steps on one shared adder, then a sign fix-up cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic clk,
  input  logic reset,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  muldiv_state_t state;
  muldiv_op_t    op_q;
  logic          sign_a;
  logic          sign_b;
  logic [N-1:0]  opnd;
  logic [N-1:0]  acc;
  logic [N-1:0]  lo_w;
  logic [CW-1:0] cnt;
  logic          busy_q;
  logic          done_q;
  logic          dz_q;
  logic [N-1:0]  hi_q;
  logic [N-1:0]  lo_q;

  logic           div_op;
  logic           in_sgn;
  logic           msb;
  logic           alu_co;
  logic           neg_q;
  logic           dz;
  logic [N-1:0]   sh;
  logic [N-1:0]   alu_x;
  logic [N-1:0]   alu_y;
  logic [N-1:0]   alu_s;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic [N-1:0]   q_fix;
  logic [N-1:0]   r_fix;
  logic [2*N-1:0] prod;
  logic [2*N-1:0] prod_fix;

  assign in_sgn = is_signed(bus.op);
  assign a_mag  = (in_sgn && bus.a[N-1]) ? -bus.a : bus.a;
  assign b_mag  = (in_sgn && bus.b[N-1]) ? -bus.b : bus.b;

  // acc doubles as the partial product high half and the remainder
  assign div_op = is_div(op_q);
  assign msb    = acc[N-1];
  assign sh     = {acc[N-2:0], lo_w[N-1]};
  assign alu_x  = div_op ? sh : acc;
  assign alu_y  = (div_op || lo_w[0]) ? opnd : '0;

  alu_arithmatic #(.N(N)) u_alu (
    .x   (alu_x),
    .y   (alu_y),
    .sub (div_op),
    .s   (alu_s),
    .co  (alu_co)
  );

  assign neg_q    = sign_a ^ sign_b;
  assign dz       = div_op && (opnd == '0);
  assign prod     = {acc, lo_w};
  assign prod_fix = neg_q ? -prod : prod;
  assign q_fix    = neg_q ? -lo_w : lo_w;
  assign r_fix    = sign_a ? -acc : acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= MD_IDLE;
      op_q   <= MD_MULT;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      lo_w   <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        MD_IDLE: begin
          if (bus.start && !bus.cancel) begin
            state  <= MD_CALC;
            busy_q <= 1'b1;
            op_q   <= bus.op;
            sign_a <= in_sgn & bus.a[N-1];
            sign_b <= in_sgn & bus.b[N-1];
            opnd   <= is_div(bus.op) ? b_mag : a_mag;
            lo_w   <= is_div(bus.op) ? a_mag : b_mag;
            acc    <= '0;
            cnt    <= '0;
            dz_q   <= 1'b0;
          end
        end
        MD_CALC: begin
          if (bus.cancel) begin
            state  <= MD_IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= MD_FIX;
            if (!div_op) begin
              acc  <= {alu_co, alu_s[N-1:1]};
              lo_w <= {alu_s[0], lo_w[N-1:1]};
            end else if (msb || !alu_co) begin
              acc  <= alu_s;
              lo_w <= {lo_w[N-2:0], 1'b1};
            end else begin
              acc  <= sh;
              lo_w <= {lo_w[N-2:0], 1'b0};
            end
          end
        end
        MD_FIX: begin
          state  <= MD_IDLE;
          busy_q <= 1'b0;
          if (!bus.cancel) begin
            done_q <= 1'b1;
            dz_q   <= dz;
            if (div_op) begin
              hi_q <= r_fix;
              lo_q <= dz ? '1 : q_fix;
            end else begin
              hi_q <= prod_fix[2*N-1:N];
              lo_q <= prod_fix[N-1:0];
            end
          end
        end
        default: begin
          state  <= MD_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed vectors,
// cancel/reset cases and a random sweep against a native model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int N = 32;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];

  muldiv_sequencer_if #(.N(N)) bus ();

  muldiv_sequencer #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(muldiv_op_t op, logic [31:0] a,
                                 logic [31:0] b);
    exp_t e;
    logic [63:0] r;
    longint sa, sb_, q, m;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    e.dz = 1'b0;
    e.at = 0;
    e.hi = '0;
    e.lo = '0;
    case (op)
      MD_MULT: begin
        r = 64'(sa * sb_);
        e.hi = r[63:32];
        e.lo = r[31:0];
      end
      MD_MULTU: begin
        r = {32'b0, a} * {32'b0, b};
        e.hi = r[63:32];
        e.lo = r[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          e.hi = a;
          e.lo = 32'hFFFF_FFFF;
          e.dz = 1'b1;
        end else if (op == MD_DIV) begin
          q = sa / sb_;
          m = sa % sb_;
          r = 64'(q);
          e.lo = r[31:0];
          r = 64'(m);
          e.hi = r[31:0];
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Callers start between edges; the next edge samples start
  task automatic issue(muldiv_op_t op, logic [31:0] a,
                       logic [31:0] b, bit push);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (push) begin
      e = model(op, a, b);
      e.at = cyc + N + 2;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: %0d results outstanding", sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 required 0 at %0d",
                 cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", bus.hi, e.hi);
        chk("lo", bus.lo, e.lo);
        chk("div_zero", 32'(bus.div_zero), 32'(e.dz));
        chk("latency", cyc, e.at);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = MD_MULT;
    bus.a      = '0;
    bus.b      = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_dz", 32'(bus.div_zero), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors; results checked by the monitor
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    wait_idle();
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1);
    wait_idle();
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1);
    wait_idle();
    issue(MD_DIVU, 32'd100, 32'd0, 1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("dz_held", 32'(bus.div_zero), 32'd1);
    issue(MD_MULTU, 32'd2, 32'd3, 1);
    chk("dz_cleared", 32'(bus.div_zero), 32'd0);
    wait_idle();
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_idle();
    issue(MD_DIVU, 32'h8000_0000, 32'd3, 1);
    wait_idle();

    // Start while busy is dropped; cancel aborts without done
    @(negedge clk);
    issue(MD_MULTU, 32'd11, 32'd13, 0);
    repeat (4) @(posedge clk);
    #1;
    issue(MD_MULT, 32'd5, 32'd5, 0);
    repeat (4) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    @(negedge clk);
    chk("cancel_busy", 32'(bus.busy), 32'd0);
    repeat (40) @(negedge clk);
    chk("cancel_hi", bus.hi, 32'd2);
    chk("cancel_lo", bus.lo, 32'h2AAA_AAAA);
    bus.cancel = 1'b1;
    issue(MD_DIVU, 32'd9, 32'd3, 0);
    bus.cancel = 1'b0;
    chk("idle_cancel_busy", 32'(bus.busy), 32'd0);
    repeat (40) @(negedge clk);

    // Asynchronous reset mid-CALC
    issue(MD_MULTU, 32'd7, 32'd9, 0);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_hi", bus.hi, 32'd0);
    chk("arst_lo", bus.lo, 32'd0);
    chk("arst_dz", 32'(bus.div_zero), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Random sweep, back-to-back on each done cycle
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 200; i++) begin
        logic [31:0] ra, rb;
        ra = $urandom;
        rb = $urandom;
        if (i % 4 == 1) rb = $urandom_range(1, 15);
        if (i % 25 == 0) rb = 32'd0;
        if (i % 50 == 3) ra = 32'h8000_0000;
        issue(muldiv_op_t'(2'(k)), ra, rb, 1);
        wait_idle();
      end
    end

    repeat (40) @(negedge clk);
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_fail);
    $finish;
  end

endmodule
